// File: rtl/birth_matcher.sv
// Stream matcher for the BCD digit sequence 1,9,9,7,0,7,2,8: tracks progress, flags and counts matches.
// Optional idle-abandon timer enabled by defining BIRTH_MATCHER_TIMEOUT_EN.
module birth_matcher #(
  parameter int unsigned CNT_W   = 8
`ifdef BIRTH_MATCHER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [3:0]       din,
  input  logic             din_valid,
  output logic [2:0]       idx,
  output logic [3:0]       exp_digit,
  output logic             match,
  output logic             bad_digit,
  output logic [CNT_W-1:0] match_cnt
`ifdef BIRTH_MATCHER_TIMEOUT_EN
  , output logic           timeout
`endif
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             match_q, match_d;
  logic             bad_q, bad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef BIRTH_MATCHER_TIMEOUT_EN
  localparam int unsigned  TMR_W    = 16;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;
`endif

  // Next expected digit, decoded straight from the progress state
  always_comb begin
    exp_digit = 4'd1;
    case (state_q)
      S0:      exp_digit = 4'd1;
      S1:      exp_digit = 4'd9;
      S2:      exp_digit = 4'd9;
      S3:      exp_digit = 4'd7;
      S4:      exp_digit = 4'd0;
      S5:      exp_digit = 4'd7;
      S6:      exp_digit = 4'd2;
      default: exp_digit = 4'd8;
    endcase
  end

  // Next-state and pulse logic; clr outranks any sampled digit
  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    bad_d   = 1'b0;
    cnt_d   = cnt_q;
`ifdef BIRTH_MATCHER_TIMEOUT_EN
    timer_d   = timer_q;
    timeout_d = 1'b0;
`endif
    if (clr) begin
      state_d = S0;
      cnt_d   = '0;
`ifdef BIRTH_MATCHER_TIMEOUT_EN
      timer_d = '0;
`endif
    end else if (din_valid) begin
`ifdef BIRTH_MATCHER_TIMEOUT_EN
      timer_d = '0;
`endif
      if (din > 4'd9) begin
        state_d = S0;
        bad_d   = 1'b1;
      end else if (din == exp_digit) begin
        if (state_q == S7) begin
          state_d = S0;
          match_d = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = state_e'(3'(state_q) + 3'd1);
        end
      end else begin
        // No border in the sequence: a '1' is the only possible restart point
        state_d = (din == 4'd1) ? S1 : S0;
      end
    end
`ifdef BIRTH_MATCHER_TIMEOUT_EN
    else if (state_q == S0) begin
      timer_d = '0;
    end else if (timer_q == TMR_LAST) begin
      state_d   = S0;
      timer_d   = '0;
      timeout_d = 1'b1;
    end else begin
      timer_d = timer_q + TMR_ONE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
      match_q <= 1'b0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BIRTH_MATCHER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

  assign idx       = 3'(state_q);
  assign match     = match_q;
  assign bad_digit = bad_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_birth_matcher.sv
// Scoreboard bench for birth_matcher: a suffix-search reference model predicts each cycle,
// a monitor compares after every rising edge.
module tb_birth_matcher;

  localparam int unsigned CNT_W = 8;
`ifdef BIRTH_MATCHER_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 4;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic [3:0]       din = 4'd0;
  logic             din_valid = 1'b0;
  logic [2:0]       idx;
  logic [3:0]       exp_digit;
  logic             match;
  logic             bad_digit;
  logic [CNT_W-1:0] match_cnt;
`ifdef BIRTH_MATCHER_TIMEOUT_EN
  logic             timeout;
`endif

  birth_matcher #(
    .CNT_W(CNT_W)
`ifdef BIRTH_MATCHER_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .din(din),
    .din_valid(din_valid),
    .idx(idx),
    .exp_digit(exp_digit),
    .match(match),
    .bad_digit(bad_digit),
    .match_cnt(match_cnt)
`ifdef BIRTH_MATCHER_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       idx;
    logic [3:0]       ed;
    logic             m;
    logic             b;
    logic [CNT_W-1:0] cnt;
    logic             to;
  } exp_t;

  exp_t       sb_q[$];
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  logic [3:0] seq [8] = '{4'd1, 4'd9, 4'd9, 4'd7, 4'd0, 4'd7, 4'd2, 4'd8};

  // Model state: the digits currently forming a sequence prefix, idle run, match count
  int m_hist[$];
  int m_idle = 0;
  int m_cnt = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    chk_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
  endfunction

  // Longest tail of the history that equals a prefix of the sequence
  function automatic int best_k();
    int n = m_hist.size();
    for (int k = (n > 8) ? 8 : n; k > 0; k--) begin
      bit ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (m_hist[n - k + i] != int'(seq[i])) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  function automatic void model_step(input logic c, input logic v, input logic [3:0] d);
    exp_t e = '0;
    if (c) begin
      m_hist.delete();
      m_cnt  = 0;
      m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      if (d > 4'd9) begin
        m_hist.delete();
        e.b = 1'b1;
      end else begin
        int k;
        m_hist.push_back(int'(d));
        k = best_k();
        if (k == 8) begin
          e.m = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
          m_hist.delete();
        end else begin
          while (m_hist.size() > k) void'(m_hist.pop_front());
        end
      end
    end else if (m_hist.size() == 0) begin
      m_idle = 0;
    end else begin
      m_idle++;
`ifdef BIRTH_MATCHER_TIMEOUT_EN
      if (m_idle == int'(TIMEOUT)) begin
        m_hist.delete();
        m_idle = 0;
        e.to   = 1'b1;
      end
`endif
    end
    e.idx = 3'(m_hist.size());
    e.ed  = seq[m_hist.size()];
    e.cnt = CNT_W'(m_cnt);
    sb_q.push_back(e);
  endfunction

  task automatic drive(input logic c, input logic v, input logic [3:0] d);
    @(negedge clk);
    clr       = c;
    din_valid = v;
    din       = d;
    model_step(c, v, d);
  endtask

  task automatic feed(input int n, input logic [3:0] ds [16]);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, ds[i]);
  endtask

  task automatic feed_seq();
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, seq[i]);
  endtask

  task automatic drain();
    int t = 0;
    drive(1'b0, 1'b0, 4'd0);
    while (sb_q.size() > 0 && t < 10) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_idx"}, 32'(idx), 32'd0);
    chk({tag, "_exp_digit"}, 32'(exp_digit), 32'd1);
    chk({tag, "_match"}, 32'(match), 32'd0);
    chk({tag, "_bad"}, 32'(bad_digit), 32'd0);
    chk({tag, "_cnt"}, 32'(match_cnt), 32'd0);
`ifdef BIRTH_MATCHER_TIMEOUT_EN
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
`endif
  endtask

  // Monitor: compare DUT outputs against the predicted cycle, just after the edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("idx", 32'(idx), 32'(e.idx));
      chk("exp_digit", 32'(exp_digit), 32'(e.ed));
      chk("match", 32'(match), 32'(e.m));
      chk("bad_digit", 32'(bad_digit), 32'(e.b));
      chk("match_cnt", 32'(match_cnt), 32'(e.cnt));
`ifdef BIRTH_MATCHER_TIMEOUT_EN
      chk("timeout", 32'(timeout), 32'(e.to));
`endif
    end
  end

  initial begin
    logic [3:0] ds [16];
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;

    // Full sequence, then overlapping restart, then a late mismatch
    feed_seq();
    ds = '{4'd1, 4'd9, 4'd1, 4'd9, 4'd9, 4'd7, 4'd0, 4'd7, 4'd2, 4'd8,
           4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    feed(10, ds);
    ds[0:3] = '{4'd1, 4'd9, 4'd9, 4'd3};
    feed(4, ds);
    // Non-BCD digit mid-sequence
    ds[0:3] = '{4'd1, 4'd9, 4'hA, 4'd9};
    feed(4, ds);
    ds[0:3] = '{4'd1, 4'd9, 4'hF, 4'd1};
    feed(4, ds);
    // clr together with a valid '1' discards the digit
    drive(1'b0, 1'b1, 4'd1);
    drive(1'b0, 1'b1, 4'd9);
    drive(1'b1, 1'b1, 4'd1);
    drive(1'b0, 1'b0, 4'd0);
    // Idle cycles hold progress (or abandon it when the timer is built in)
    drive(1'b0, 1'b1, 4'd1);
    drive(1'b0, 1'b1, 4'd9);
    repeat (4) drive(1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 4'd1);
    drive(1'b0, 1'b1, 4'd9);
    repeat (3) drive(1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 4'd9);
    repeat (6) drive(1'b0, 1'b0, 4'd0);

    // Asynchronous reset mid-sequence with a non-zero counter
    drive(1'b1, 1'b0, 4'd0);
    feed_seq();
    ds[0:2] = '{4'd1, 4'd9, 4'd9};
    feed(3, ds);
    drain();
    chk("pre_reset_idx", 32'(idx), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_hist.delete();
    m_cnt  = 0;
    m_idle = 0;

    // Randomized stream biased toward progress
    for (int n = 0; n < 3000; n++) begin
      logic c, v;
      logic [3:0] d;
      c = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 85);
      d = ($urandom_range(0, 99) < 65) ? seq[m_hist.size()] : 4'($urandom_range(0, 15));
      drive(c, v, d);
      if ($urandom_range(0, 99) < 3)
        repeat ($urandom_range(2, 6)) drive(1'b0, 1'b0, 4'd0);
    end

    // Counter saturation
    drive(1'b1, 1'b0, 4'd0);
    for (int n = 0; n < CNT_MAX + 5; n++) feed_seq();
    drain();
    chk("sat_cnt", 32'(match_cnt), 32'(CNT_MAX));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
